fifo_rr_read_arbiter: RTL and testbench

//  Read-side scheduler sharing one downstream consumer between NUM_FIFOS FIFO instances.

---
 rtl/fifo_ctrl_pkg.sv | 24 ++
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_rr_read_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_rr_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared FSM encodings and helpers for the FIFO read scheduler
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    // Ceiling log2 for sizing counters from elaboration-time parameters
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational circular first-requester search starting at ptr
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan from the far end back toward ptr so the last hit is the nearest requester at/after ptr
    always_comb begin
        logic [IW-1:0] cand;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_read_arbiter.sv
// rtl/fifo_rr_read_arbiter.sv - round-robin read scheduler with urgency priority over a FIFO bank
module fifo_rr_read_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_FIFOS    = 4,
    parameter int SRC_WIDTH    = 2,
    parameter int READ_LATENCY = 1,
    parameter int BURST_MAX    = 4
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            Enable,
    input  logic [NUM_FIFOS-1:0]            fifo_empty,
    input  logic [NUM_FIFOS-1:0]            fifo_almost_full,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data,
    input  logic                            out_ready,
    output logic [NUM_FIFOS-1:0]            fifo_read_enable,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_WIDTH-1:0]            out_src,
    output logic                            out_valid,
    output logic                            busy
);

    localparam int LAT_W   = (clog2(READ_LATENCY + 1) < 1) ? 1 : clog2(READ_LATENCY + 1);
    localparam int BURST_W = (clog2(BURST_MAX + 1) < 1) ? 1 : clog2(BURST_MAX + 1);

    state_t                 state;
    logic [SRC_WIDTH-1:0]   g;
    logic [SRC_WIDTH-1:0]   rr_ptr;
    logic [LAT_W-1:0]       lat_cnt;
    logic [BURST_W-1:0]     burst_cnt;

    logic [NUM_FIFOS-1:0]   eligible;
    logic [NUM_FIFOS-1:0]   urgent;
    logic [NUM_FIFOS-1:0]   pick_req;
    logic [NUM_FIFOS-1:0]   g_mask;
    logic [SRC_WIDTH-1:0]   pick_idx;
    logic                   pick_any;
    logic [BURST_W-1:0]     burst_next;
    logic                   may_continue;
    logic [DATA_WIDTH-1:0]  sel_data;

    // Urgent (almost-full) requesters shut everyone else out of the round-robin
    always_comb begin
        eligible     = ~fifo_empty;
        urgent       = eligible & fifo_almost_full;
        pick_req     = (|urgent) ? urgent : eligible;
        g_mask       = NUM_FIFOS'(1) << g;
        burst_next   = burst_cnt + 1'b1;
        may_continue = !fifo_empty[g] && (burst_next < BURST_W'(BURST_MAX)) && !(|(urgent & ~g_mask));
    end

    // Word from the current grantee, selected with constant slices
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (g == SRC_WIDTH'(i)) begin
                sel_data = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    rr_picker #(
        .N  (NUM_FIFOS),
        .IW (SRC_WIDTH)
    ) u_picker (
        .req     (pick_req),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Strobe only in GRANT and only while running, so a frozen GRANT never pops twice
    assign fifo_read_enable = (Enable && (state == ST_GRANT)) ? g_mask : '0;
    assign busy             = (state != ST_IDLE);

    // Scheduler FSM; OUTPUT either re-grants the same FIFO or rotates the pointer and goes idle
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            burst_cnt <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (Enable) begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g     <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    lat_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                        state <= ST_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    out_data  <= sel_data;
                    out_src   <= g;
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (may_continue) begin
                            burst_cnt <= burst_next;
                            state     <= ST_GRANT;
                        end else begin
                            burst_cnt <= '0;
                            rr_ptr    <= (g == SRC_WIDTH'(NUM_FIFOS - 1)) ? '0 : g + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// tb/tb_fifo_rr_read_arbiter.sv - self-checking bench with FIFO bank model and transaction-level scheduler model
module tb_fifo_rr_read_arbiter;

    localparam int NF = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int RL = 1;
    localparam int BM = 4;

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Enable = 1'b1;
    logic              out_ready = 1'b0;
    logic [NF-1:0]     fifo_empty = '1;
    logic [NF-1:0]     af = '0;
    logic [NF*DW-1:0]  fdata = '0;
    logic [NF-1:0]     fifo_read_enable;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_valid;
    logic              busy;

    fifo_rr_read_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_FIFOS    (NF),
        .SRC_WIDTH    (SW),
        .READ_LATENCY (RL),
        .BURST_MAX    (BM)
    ) dut (
        .clk              (clk),
        .Reset            (Reset),
        .Enable           (Enable),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (af),
        .fifo_data        (fdata),
        .out_ready        (out_ready),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_src          (out_src),
        .out_valid        (out_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]    fq [NF][$];
    logic [SW+DW-1:0] sb [$];
    int pulse_log [$];
    int pulse_t [$];
    int xfer_log [$];

    int ecnt = 0;
    int rr_m = 0;
    int burst_m = 0;
    int g_m = 0;
    int exp_m = 0;
    bit exp_v = 1'b0;
    bit idle_m = 1'b1;
    int idle_from = 0;
    int pulse_e = 0;
    bit prev_valid = 1'b0;
    logic [NF-1:0] re_neg = '0;
    bit rst_neg = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void update_flags();
        for (int i = 0; i < NF; i++) fifo_empty[i] = (fq[i].size() == 0);
    endfunction

    // Round-robin rule: urgent non-empty FIFOs compete alone, first one at/after ptr wins
    function automatic int pick(input logic [NF-1:0] emp, input logic [NF-1:0] a, input int ptr);
        logic [NF-1:0] elig;
        logic [NF-1:0] urg;
        logic [NF-1:0] req;
        elig = ~emp;
        urg  = elig & a;
        req  = (urg != 0) ? urg : elig;
        for (int k = 0; k < NF; k++) begin
            if (req[(ptr + k) % NF]) return (ptr + k) % NF;
        end
        return -1;
    endfunction

    task automatic push(input int i, input int n);
        repeat (n) fq[i].push_back(DW'($urandom));
        update_flags();
    endtask

    // Advance one clock; the FIFO bank pops the word whose strobe was seen on this edge
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (re_neg[i] && fq[i].size() > 0) begin
                logic [DW-1:0] d;
                d = fq[i].pop_front();
                fdata[i*DW +: DW] = d;
                if (rst_neg) sb.push_back({SW'(i), d});
            end
        end
        re_neg = '0;
        update_flags();
    endtask

    // Scheduler model evaluated once per cycle, between edges
    always @(negedge clk) begin : monitor
        int ri;
        bit cont;
        logic [NF-1:0] urg;
        re_neg  = fifo_read_enable;
        rst_neg = Reset;
        if (!Reset) begin
            sb.delete();
            exp_v     = 1'b0;
            idle_m    = 1'b1;
            idle_from = ecnt + 1;
            rr_m      = 0;
            burst_m   = 0;
        end else begin
            if (exp_v && Enable) check("grant", fifo_read_enable, 32'(1 << exp_m));
            else check("no_grant", fifo_read_enable, 0);
            if (fifo_read_enable != 0) begin
                ri = 0;
                for (int i = 0; i < NF; i++) if (fifo_read_enable[i]) ri = i;
                check("rd_not_empty", fq[ri].size() != 0, 1);
                check("rd_no_space", out_valid, 0);
                pulse_log.push_back(ri);
                pulse_t.push_back(ecnt);
                pulse_e = ecnt;
                g_m     = exp_v ? exp_m : ri;
                exp_v   = 1'b0;
            end
            if (out_valid && !prev_valid) check("cap_latency", ecnt - pulse_e, 2 + RL);
            if (out_valid) check("busy_out", busy, 1);
            if (Enable && out_valid && out_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) check("xfer_word", {out_src, out_data}, sb.pop_front());
                xfer_log.push_back(int'(out_src));
                urg  = ~fifo_empty & af;
                cont = !fifo_empty[g_m] && (burst_m + 1 < BM) && ((urg & ~(NF'(1) << g_m)) == 0);
                if (cont) begin
                    burst_m = burst_m + 1;
                    exp_m   = g_m;
                    exp_v   = 1'b1;
                end else begin
                    burst_m   = 0;
                    rr_m      = (g_m + 1) % NF;
                    idle_m    = 1'b1;
                    idle_from = ecnt + 1;
                end
            end
            if (idle_m && Enable && ecnt >= idle_from && fifo_empty != '1) begin
                exp_m  = pick(fifo_empty, af, rr_m);
                exp_v  = 1'b1;
                idle_m = 1'b0;
            end
        end
        prev_valid = (out_valid === 1'b1);
        if (Enable || !Reset) ecnt++;
    end

    task automatic wait_xfers(input int n, input int budget);
        int c = 0;
        while (xfer_log.size() < n && c < budget) begin tick(); c++; end
        check("tmo_xfer", xfer_log.size() >= n, 1);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int c = 0;
        while (pulse_log.size() < n && c < budget) begin tick(); c++; end
        check("tmo_pulse", pulse_log.size() >= n, 1);
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!out_valid && c < budget) begin tick(); c++; end
        check("tmo_valid", out_valid, 1);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        Enable = 1'b1; out_ready = 1'b1; af = '0;
        while (!(fifo_empty == '1 && sb.size() == 0 && !busy && !out_valid) && c < budget) begin
            tick(); c++;
        end
        check("tmo_drain", busy, 0);
    endtask

    task automatic clear_logs();
        pulse_log.delete(); pulse_t.delete(); xfer_log.delete();
    endtask

    initial begin
        logic [DW-1:0] hold;
        int np;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_re", fifo_read_enable, 0);
        check("rst_data", out_data, 0);
        check("rst_src", out_src, 0);
        tick();
        Reset = 1'b1;

        // Full bank, bursts of BM then rotate
        for (int i = 0; i < NF; i++) push(i, 8);
        out_ready = 1'b1;
        wait_xfers(8, 200);
        for (int k = 0; k < 8; k++) check("burst_order", xfer_log[k], k / BM);
        for (int k = 1; k < BM; k++) check("pulse_gap", pulse_t[k] - pulse_t[k-1], 3 + RL);

        // Reset while a word is held in the output register
        out_ready = 1'b0;
        wait_valid(50);
        clear_logs();
        Reset = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        @(negedge clk);
        check("rst2_valid", out_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_re", fifo_read_enable, 0);
        wait_pulses(1, 20);
        check("rst2_first", pulse_log[0], 0);
        drain(600);

        // Urgency cuts a burst short
        clear_logs();
        push(0, 6);
        wait_pulses(1, 20);
        push(2, 3);
        af[2] = 1'b1;
        wait_xfers(2, 50);
        check("urg_first", xfer_log[0], 0);
        check("urg_next", xfer_log[1], 2);
        drain(300);

        // Back-pressure holds the output and blocks further reads
        clear_logs();
        out_ready = 1'b0;
        push(1, 3);
        wait_valid(30);
        hold = out_data;
        np = pulse_log.size();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, hold);
            check("bp_no_read", pulse_log.size(), np);
        end
        out_ready = 1'b1;
        tick();
        check("bp_one_xfer", xfer_log.size(), 1);
        drain(200);

        // Short run from the last FIFO, then pointer wraps to 0
        clear_logs();
        push(3, 2);
        drain(100);
        check("f3_count", xfer_log.size(), 2);
        check("f3_src0", xfer_log[0], 3);
        check("f3_src1", xfer_log[1], 3);
        check("f3_idle", busy, 0);
        clear_logs();
        push(0, 1);
        push(2, 1);
        wait_pulses(1, 20);
        check("wrap_first", pulse_log[0], 0);
        drain(100);

        // Freeze during WAIT
        clear_logs();
        push(1, 1);
        wait_pulses(1, 20);
        Enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frz_valid", out_valid, 0);
        end
        Enable = 1'b1;
        wait_xfers(1, 20);
        check("frz_src", xfer_log[0], 1);
        drain(100);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 3) == 0 && fq[i].size() < 8) push(i, 1);
                af[i] = ($urandom_range(0, 7) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            Enable    = ($urandom_range(0, 15) != 0);
        end
        drain(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
